seg7_stream_monitor: RTL and testbench



---
 rtl/seg7_stream_monitor.sv | 171 +++++++++++++++++
 tb/tb_seg7_stream_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_stream_monitor.sv
// seg7_stream_monitor
// Watches a seven-segment bus (bit0=a .. bit6=g, active-high), accepts a
// pattern only after it has been stable for STABLE_CYCLES enabled samples,
// decodes it to BCD and checks that consecutive digits count up modulo 10.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ena              enable; low freezes state (pulses drop on the next edge)
//   seg_in[6:0]      segment bus being monitored
//   clr_cnt          synchronous clear of both counters (beats increments)
//   digit[3:0]       last accepted legal digit
//   digit_valid      accepted pattern is a legal digit
//   new_digit        one-cycle pulse when a legal digit is accepted
//   invalid_pattern  accepted pattern is neither blank nor a legal digit
//   seq_error        one-cycle pulse when a digit is not previous+1 mod 10
//   err_count        saturating count of invalid patterns + sequence errors
//   change_count     wrapping count of accepted legal digits
module seg7_stream_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [6:0]       seg_in,
  input  logic             clr_cnt,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             new_digit,
  output logic             invalid_pattern,
  output logic             seq_error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] change_count
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  logic [6:0]       s_q, s_d;
  logic [3:0]       stab_q, stab_d;
  logic [6:0]       acc_q, acc_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, digit_valid_d;
  logic             new_digit_q, new_digit_d;
  logic             invalid_q, invalid_d;
  logic             seq_error_q, seq_error_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] chg_q, chg_d;
  logic [3:0]       prev_q, prev_d;
  logic             have_prev_q, have_prev_d;

  logic [3:0] dec_val;
  logic       dec_legal;
  logic [3:0] prev_next;

  // Decode of the candidate pattern (the one about to be accepted).
  always_comb begin
    dec_val   = 4'd0;
    dec_legal = 1'b1;
    case (s_q)
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  assign prev_next = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;

  always_comb begin
    s_d           = s_q;
    stab_d        = stab_q;
    acc_d         = acc_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    invalid_d     = invalid_q;
    err_d         = err_q;
    chg_d         = chg_q;
    prev_d        = prev_q;
    have_prev_d   = have_prev_q;
    // Pulses are always one cycle; with ena low they simply drop.
    new_digit_d   = 1'b0;
    seq_error_d   = 1'b0;

    if (ena) begin
      if (seg_in != s_q) begin
        s_d    = seg_in;
        stab_d = 4'd1;
      end else if (stab_q != STAB_MAX) begin
        stab_d = stab_q + 4'd1;
      end

      // Acceptance uses the window as it stood before this edge's sample.
      if ((stab_q == STAB_MAX) && (s_q != acc_q)) begin
        acc_d = s_q;
        if (dec_legal) begin
          digit_d       = dec_val;
          digit_valid_d = 1'b1;
          invalid_d     = 1'b0;
          new_digit_d   = 1'b1;
          chg_d         = chg_q + CNT_W'(1);
          if (have_prev_q && (dec_val != prev_next)) begin
            seq_error_d = 1'b1;
            if (err_q != '1) err_d = err_q + CNT_W'(1);
          end
          prev_d      = dec_val;
          have_prev_d = 1'b1;
        end else if (s_q == 7'h00) begin
          digit_valid_d = 1'b0;
          invalid_d     = 1'b0;
          have_prev_d   = 1'b0;
        end else begin
          digit_valid_d = 1'b0;
          invalid_d     = 1'b1;
          have_prev_d   = 1'b0;
          if (err_q != '1) err_d = err_q + CNT_W'(1);
        end
      end

      if (clr_cnt) begin
        err_d = '0;
        chg_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q           <= '0;
      stab_q        <= '0;
      acc_q         <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      new_digit_q   <= 1'b0;
      invalid_q     <= 1'b0;
      seq_error_q   <= 1'b0;
      err_q         <= '0;
      chg_q         <= '0;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
    end else begin
      s_q           <= s_d;
      stab_q        <= stab_d;
      acc_q         <= acc_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      new_digit_q   <= new_digit_d;
      invalid_q     <= invalid_d;
      seq_error_q   <= seq_error_d;
      err_q         <= err_d;
      chg_q         <= chg_d;
      prev_q        <= prev_d;
      have_prev_q   <= have_prev_d;
    end
  end

  assign digit           = digit_q;
  assign digit_valid     = digit_valid_q;
  assign new_digit       = new_digit_q;
  assign invalid_pattern = invalid_q;
  assign seq_error       = seq_error_q;
  assign err_count       = err_q;
  assign change_count    = chg_q;

endmodule

// File: tb/tb_seg7_stream_monitor.sv
module tb_seg7_stream_monitor;

  localparam int ST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic       clr_cnt = 1'b0;
  logic [3:0] digit;
  logic       digit_valid, new_digit, invalid_pattern, seq_error;
  logic [7:0] err_count, change_count;

  int checks = 0;
  int errors = 0;

  seg7_stream_monitor #(.STABLE_CYCLES(ST), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .clr_cnt(clr_cnt),
    .digit(digit), .digit_valid(digit_valid), .new_digit(new_digit),
    .invalid_pattern(invalid_pattern), .seq_error(seq_error),
    .err_count(err_count), .change_count(change_count)
  );

  always #5 clk = ~clk;

  logic [23:0] dut_vec;
  assign dut_vec = {digit, digit_valid, new_digit, invalid_pattern, seq_error,
                    err_count, change_count};

  // Reference model: acceptance = "the last ST enabled samples were all the
  // same pattern and it differs from what was last accepted".
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] hist [$];
  logic [6:0] m_acc;
  int m_digit, m_err, m_chg, m_prev;
  bit m_dv, m_nd, m_inv, m_se, m_hp;

  function automatic logic [23:0] exp_vec();
    return {4'(m_digit), m_dv, m_nd, m_inv, m_se, 8'(m_err), 8'(m_chg)};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_acc = 7'h00; m_digit = 0; m_err = 0; m_chg = 0; m_prev = 0;
    m_dv = 0; m_nd = 0; m_inv = 0; m_se = 0; m_hp = 0;
  endtask

  task automatic model_edge(input logic [6:0] seg, input logic en, input logic clr);
    bit stable;
    int v;
    logic [6:0] p;
    m_nd = 0;
    m_se = 0;
    if (!en) return;
    stable = (hist.size() >= ST);
    p = (hist.size() > 0) ? hist[hist.size()-1] : 7'h00;
    for (int i = 0; i < hist.size(); i++) if (hist[i] != p) stable = 0;
    if (stable && p != m_acc) begin
      m_acc = p;
      v = -1;
      for (int k = 0; k < 10; k++) if (seg_tab[k] == p) v = k;
      if (v >= 0) begin
        m_digit = v; m_dv = 1; m_inv = 0; m_nd = 1;
        m_chg = (m_chg + 1) % 256;
        if (m_hp && v != (m_prev + 1) % 10) begin
          m_se = 1;
          if (m_err < 255) m_err++;
        end
        m_prev = v; m_hp = 1;
      end else if (p == 7'h00) begin
        m_dv = 0; m_inv = 0; m_hp = 0;
      end else begin
        m_dv = 0; m_inv = 1; m_hp = 0;
        if (m_err < 255) m_err++;
      end
    end
    if (clr) begin
      m_err = 0; m_chg = 0;
    end
    hist.push_back(seg);
    if (hist.size() > ST) void'(hist.pop_front());
  endtask

  task automatic cyc(input logic [6:0] seg, input logic en, input logic clr);
    seg_in = seg; ena = en; clr_cnt = clr;
    @(posedge clk);
    model_edge(seg, en, clr);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b0; clr_cnt = 1'b0; seg_in = 7'h00;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== 24'h0) begin
      errors++; $display("FAIL reset_state: got %h exp %h", dut_vec, 24'h0);
    end
  endtask

  task automatic test_first_digit();
    int pulses = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(7'h06, 1'b1, 1'b0);
      if (new_digit === 1'b1) pulses++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL first_digit c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (digit !== 4'd1 || digit_valid !== 1'b1 || change_count !== 8'd1 || pulses != 1) begin
      errors++;
      $display("FAIL first_digit_final: digit %0d valid %b chg %0d pulses %0d exp 1 1 1 1",
               digit, digit_valid, change_count, pulses);
    end
  endtask

  task automatic test_count_up();
    int pulses = 0, serr = 0;
    do_reset();
    for (int d = 0; d < 11; d++) begin
      for (int c = 0; c < 10; c++) begin
        cyc(seg_tab[d % 10], 1'b1, 1'b0);
        if (new_digit === 1'b1) pulses++;
        if (seq_error === 1'b1) serr++;
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL count_up d%0d c%0d: got %h exp %h", d, c, dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if (pulses != 11 || serr != 0 || err_count !== 8'd0 || change_count !== 8'd11 || digit !== 4'd0) begin
      errors++;
      $display("FAIL count_up_final: pulses %0d serr %0d err %0d chg %0d digit %0d exp 11 0 0 11 0",
               pulses, serr, err_count, change_count, digit);
    end
  endtask

  task automatic test_glitch_and_seq();
    int pulses = 0;
    logic [6:0] pat [4] = '{7'h06, 7'h5B, 7'h06, 7'h4F};
    int len [4] = '{10, 2, 10, 10};
    bit saw_se = 0;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < len[p]; c++) begin
        cyc(pat[p], 1'b1, 1'b0);
        if (p == 1 || p == 2) if (new_digit === 1'b1) pulses++;
        if (p == 3 && seq_error === 1'b1) saw_se = 1;
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL glitch p%0d c%0d: got %h exp %h", p, c, dut_vec, exp_vec());
        end
      end
      if (p == 2) begin
        checks++;
        if (pulses != 0 || digit !== 4'd1) begin
          errors++; $display("FAIL glitch_reject: pulses %0d digit %0d exp 0 1", pulses, digit);
        end
      end
    end
    checks++;
    if (!saw_se || err_count !== 8'd1 || digit !== 4'd3) begin
      errors++; $display("FAIL seq_error: saw %b err %0d digit %0d exp 1 1 3", saw_se, err_count, digit);
    end
  endtask

  task automatic test_invalid();
    for (int c = 0; c < 10; c++) begin
      cyc(7'h49, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL invalid c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (invalid_pattern !== 1'b1 || digit_valid !== 1'b0 || err_count !== 8'd2 || digit !== 4'd3) begin
      errors++;
      $display("FAIL invalid_state: inv %b dv %b err %0d digit %0d exp 1 0 2 3",
               invalid_pattern, digit_valid, err_count, digit);
    end
    for (int c = 0; c < 10; c++) begin
      cyc(7'h66, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL after_invalid c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (digit !== 4'd4 || digit_valid !== 1'b1 || invalid_pattern !== 1'b0 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL after_invalid_state: digit %0d dv %b inv %b err %0d exp 4 1 0 2",
               digit, digit_valid, invalid_pattern, err_count);
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    for (int n = 0; n < 260; n++) begin
      for (int c = 0; c < 5; c++) begin
        cyc((n % 2 == 0) ? 7'h49 : 7'h4A, 1'b1, 1'b0);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL saturate n%0d c%0d: got %h exp %h", n, c, dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++; $display("FAIL saturate_final: err %0d exp 255", err_count);
    end
    // New invalid pattern is accepted on its 5th enabled edge; clear exactly there.
    for (int c = 0; c < 6; c++) begin
      cyc(7'h01, 1'b1, (c == 4));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL clear c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (err_count !== 8'd0 || change_count !== 8'd0 || invalid_pattern !== 1'b1) begin
      errors++;
      $display("FAIL clear_wins: err %0d chg %0d inv %b exp 0 0 1", err_count, change_count, invalid_pattern);
    end
  endtask

  task automatic test_ena();
    int pulse_at = -1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc(7'h06, !(c >= 2 && c < 7), 1'b0);
      if (new_digit === 1'b1 && pulse_at < 0) pulse_at = c;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ena c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (pulse_at != 9) begin
      errors++; $display("FAIL ena_resume: pulse at cycle %0d exp 9", pulse_at);
    end
    // ena dropping on the edge right after acceptance must still end the pulse.
    for (int c = 0; c < 7; c++) begin
      cyc(7'h5B, (c != 5), 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ena_pulse c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) cyc(7'h4F, 1'b1, 1'b0);
    rst_n = 1'b0; #1;
    model_reset();
    checks++;
    if (dut_vec !== 24'h0) begin
      errors++; $display("FAIL reset_mid_window: got %h exp 0", dut_vec);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 5; c++) cyc(7'h6D, 1'b1, 1'b0);
    checks++;
    if (new_digit !== 1'b1) begin
      errors++; $display("FAIL reset_pulse_setup: new_digit %b exp 1", new_digit);
    end
    rst_n = 1'b0; #1;
    model_reset();
    checks++;
    if (dut_vec !== 24'h0) begin
      errors++; $display("FAIL reset_mid_pulse: got %h exp 0", dut_vec);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    // Fresh baseline: 3 after reset is not an error even though 5 came before.
    for (int c = 0; c < 6; c++) begin
      cyc(7'h4F, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_baseline c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] pat;
    int r, hold;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r < 14) pat = seg_tab[$urandom_range(0, 9)];
      else if (r < 16) pat = 7'h00;
      else pat = 7'($urandom);
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        cyc(pat, ($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0));
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL random n%0d c%0d: got %h exp %h", n, c, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_count_up();
    test_glitch_and_seq();
    test_invalid();
    test_saturate_clear();
    test_ena();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
